// File: rtl/dsram_pkg.sv
// Shared definitions for the data SRAM responder: FSM state encoding and the
// largest supported wait-state count.
package dsram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dsram_state_e;

  localparam int unsigned DSRAM_WAIT_MAX = 7;

endpackage

// File: rtl/dsram_bank.sv
// Byte-writable 2^DEPTH_LOG2 x 32 synchronous array with a registered read port.
// Only the read register is reset; the array contents are left as they are.
module dsram_bank #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder with 0..7 programmable wait-states (IDLE/WAIT/RESP FSM).
// Optional macro DSRAM_RANGE_CHK_EN adds out-of-range detection and data_sram_err.
module data_sram_resp #(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        data_sram_stallreq
`ifdef DSRAM_RANGE_CHK_EN
  ,
  output logic        data_sram_err
`endif
);

  import dsram_pkg::*;

  localparam logic [2:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES > DSRAM_WAIT_MAX) begin : g_wait_range
    $error("data_sram_resp: WAIT_CYCLES exceeds DSRAM_WAIT_MAX");
  end

  dsram_state_e state_q;
  logic [2:0]   cnt_q;
  logic [31:0]  addr_q;
  logic [3:0]   wen_q;
  logic [31:0]  wdata_q;
  logic         rvalid_q;

  logic         acc_go;
  logic [31:0]  acc_addr;
  logic [3:0]   acc_wen;
  logic [31:0]  acc_wdata;
  logic         acc_oor;
  logic [3:0]   bank_we;
  logic         bank_re;
  logic [31:0]  bank_rdata;
  logic         stall;

  // Zero wait-states perform straight from the ports; otherwise from the latched request.
  always_comb begin
    acc_go    = (state_q == WAIT) && (cnt_q == 3'd0);
    acc_addr  = addr_q;
    acc_wen   = wen_q;
    acc_wdata = wdata_q;
    if (WAIT_CYCLES == 0) begin
      acc_go    = (state_q == IDLE) && data_sram_en;
      acc_addr  = data_sram_addr;
      acc_wen   = data_sram_wen;
      acc_wdata = data_sram_wdata;
    end
  end

`ifdef DSRAM_RANGE_CHK_EN
  assign acc_oor = (acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
`else
  assign acc_oor = 1'b0;
`endif

  // Without the range check the upper address bits simply wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^acc_addr;

  assign bank_we = (acc_go && !acc_oor) ? acc_wen : 4'b0000;
  assign bank_re = acc_go && (acc_wen == 4'b0000) && !acc_oor;

  dsram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (bank_we),
    .re_i   (bank_re),
    .addr_i (acc_addr[DEPTH_LOG2+1:2]),
    .wdata_i(acc_wdata),
    .rdata_o(bank_rdata)
  );

`ifdef DSRAM_RANGE_CHK_EN
  logic err_q;
  logic rd_zero_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      wen_q    <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef DSRAM_RANGE_CHK_EN
      err_q     <= 1'b0;
      rd_zero_q <= 1'b0;
`endif
    end else begin
      rvalid_q <= acc_go;
`ifdef DSRAM_RANGE_CHK_EN
      err_q <= acc_go && acc_oor;
      // An out-of-range read returns zero until the next read completes.
      if (acc_go && (acc_wen == 4'b0000)) begin
        rd_zero_q <= acc_oor;
      end
`endif
      unique case (state_q)
        IDLE: begin
          if (data_sram_en && (WAIT_CYCLES != 0)) begin
            state_q <= WAIT;
            cnt_q   <= CNT_LOAD;
            addr_q  <= data_sram_addr;
            wen_q   <= data_sram_wen;
            wdata_q <= data_sram_wdata;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (WAIT_CYCLES != 0) begin
      case (state_q)
        IDLE:    stall = data_sram_en;
        WAIT:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  assign data_sram_stallreq = stall;
  assign data_sram_rvalid   = rvalid_q;

`ifdef DSRAM_RANGE_CHK_EN
  assign data_sram_err   = err_q;
  assign data_sram_rdata = rd_zero_q ? 32'd0 : bank_rdata;
`else
  assign data_sram_rdata = bank_rdata;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three instances (0, 3 and 2 wait-states) checked every
// cycle against a transaction-timeline model, plus hand-computed directed expectations.
module tb_data_sram_resp;

  localparam int DL2 = 12;
`ifdef DSRAM_RANGE_CHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif
  localparam logic [31:0] EXP_WORD0 = RCHK ? 32'h55667788 : 32'h99999999;

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  logic        clk;
  logic        rstn   [3];
  logic        en     [3];
  logic [3:0]  wen    [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic        rvalid [3];
  logic        stall  [3];
  logic        err    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_resp #(
      .DEPTH_LOG2 (DL2),
      .WAIT_CYCLES(wc(g))
    ) u_dut (
      .clk               (clk),
      .rst_n             (rstn[g]),
      .data_sram_en      (en[g]),
      .data_sram_wen     (wen[g]),
      .data_sram_addr    (addr[g]),
      .data_sram_wdata   (wdata[g]),
      .data_sram_rdata   (rdata[g]),
      .data_sram_rvalid  (rvalid[g]),
      .data_sram_stallreq(stall[g])
`ifdef DSRAM_RANGE_CHK_EN
      ,
      .data_sram_err     (err[g])
`endif
    );
`ifndef DSRAM_RANGE_CHK_EN
    assign err[g] = 1'b0;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: memory image and the timeline of each outstanding access.
  logic [31:0] mm [3][4096];
  int          cyc = 0;
  int          free_at   [3];
  int          acc_edge  [3];
  int          perf_edge [3];
  int          rv_edge   [3];
  bit          pend      [3];
  logic [31:0] pa [3];
  logic [31:0] pd [3];
  logic [3:0]  pw [3];
  logic [31:0] mrd  [3];
  bit          merr [3];

  task automatic model_access(input int k, input logic [31:0] a, input logic [3:0] w,
                              input logic [31:0] d);
    int idx;
    idx = int'((a >> 2) & 32'hFFF);
    merr[k] = RCHK && ((a >> (DL2 + 2)) != 0);
    if (merr[k]) begin
      if (w == 4'b0000) mrd[k] = 32'd0;
    end else if (w == 4'b0000) begin
      mrd[k] = mm[k][idx];
    end else begin
      for (int i = 0; i < 4; i++)
        if (w[i]) mm[k][idx][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!rstn[k]) begin
        pend[k] = 1'b0; free_at[k] = 0; rv_edge[k] = -1; mrd[k] = 32'd0; merr[k] = 1'b0;
      end else begin
        if (pend[k] && cyc == perf_edge[k]) begin
          model_access(k, pa[k], pw[k], pd[k]);
          rv_edge[k] = cyc;
          pend[k] = 1'b0;
        end
        if (cyc >= free_at[k] && en[k]) begin
          if (wc(k) == 0) begin
            model_access(k, addr[k], wen[k], wdata[k]);
            rv_edge[k] = cyc;
            free_at[k] = cyc + 1;
          end else begin
            pend[k] = 1'b1; acc_edge[k] = cyc; perf_edge[k] = cyc + wc(k);
            pa[k] = addr[k]; pw[k] = wen[k]; pd[k] = wdata[k];
            free_at[k] = cyc + wc(k) + 2;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        logic ev, es, ee;
        logic [31:0] ed;
        int e;
        e = cyc + 1;
        if (!rstn[k]) begin
          ev = 1'b0; ee = 1'b0; ed = 32'd0; es = (wc(k) != 0) && en[k];
        end else begin
          ev = (rv_edge[k] == cyc);
          ee = ev && merr[k];
          ed = mrd[k];
          es = (wc(k) != 0) && ((pend[k] && e > acc_edge[k] && e <= perf_edge[k]) ||
                                (e >= free_at[k] && en[k]));
        end
        check($sformatf("cyc%0d rvalid[%0d]", cyc, k), 32'(rvalid[k]), 32'(ev));
        check($sformatf("cyc%0d stallreq[%0d]", cyc, k), 32'(stall[k]), 32'(es));
        check($sformatf("cyc%0d rdata[%0d]", cyc, k), rdata[k], ed);
`ifdef DSRAM_RANGE_CHK_EN
        check($sformatf("cyc%0d err[%0d]", cyc, k), 32'(err[k]), 32'(ee));
`endif
      end
    end
  end

  int rvc1 = 0;
  always @(negedge clk) if (rvalid[1]) rvc1++;

  // Caller is at posedge+1; returns at posedge+1 after the edge that releases the requester.
  task automatic access(input int k, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, output int stalls);
    bit done;
    en[k] = 1'b1; addr[k] = a; wen[k] = w; wdata[k] = d;
    stalls = 0; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (stall[k]) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      nchk++; nerr++;
      $display("FAIL access_timeout[%0d]: stalled %0d cycles, required release", k, stalls);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < 3; k++) begin en[k] = 1'b0; wen[k] = 4'b0000; end
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int s;
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b1; en[k] = 1'b0; wen[k] = 4'b0; addr[k] = 32'd0; wdata[k] = 32'd0;
      free_at[k] = 0; rv_edge[k] = -1; pend[k] = 1'b0; mrd[k] = 32'd0; merr[k] = 1'b0;
      acc_edge[k] = 0; perf_edge[k] = -1;
    end
    #1;
    for (int k = 0; k < 3; k++) rstn[k] = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
    check("reset_rdata0", rdata[0], 32'd0);
    check("reset_rvalid1", 32'(rvalid[1]), 32'd0);

    // Zero wait-states: full write, then read back next cycle
    access(0, 32'h10, 4'b1111, 32'hDEADBEEF, s);
    check("n0_wr_stalls", 32'(s), 32'd0);
    check("n0_wr_rvalid", 32'(rvalid[0]), 32'd1);
    check("n0_rdata_kept_by_write", rdata[0], 32'd0);
    access(0, 32'h10, 4'b0000, 32'd0, s);
    check("n0_rd_stalls", 32'(s), 32'd0);
    check("n0_rd_rvalid", 32'(rvalid[0]), 32'd1);
    check("n0_rd_data", rdata[0], 32'hDEADBEEF);

    // Byte-lane merge, back-to-back, read directly after write
    access(0, 32'h20, 4'b1111, 32'h11223344, s);
    access(0, 32'h20, 4'b0100, 32'hAAAAAAAA, s);
    access(0, 32'h20, 4'b0000, 32'd0, s);
    check("n0_lane_merge", rdata[0], 32'h11AA3344);
    access(0, 32'h23, 4'b0000, 32'd0, s);
    check("n0_addr_lsb_ignored", rdata[0], 32'h11AA3344);
    idle(3);
    check("n0_rdata_held", rdata[0], 32'h11AA3344);
    check("n0_idle_rvalid", 32'(rvalid[0]), 32'd0);

    // Three wait-states
    access(1, 32'h40, 4'b1111, 32'hCAFEF00D, s);
    check("n3_wr_stalls", 32'(s), 32'd4);
    idle(1);
    rvc1 = 0;
    access(1, 32'h40, 4'b0000, 32'd0, s);
    idle(4);
    check("n3_rd_stalls", 32'(s), 32'd4);
    check("n3_rvalid_pulses", 32'(rvc1), 32'd1);
    check("n3_rdata_held", rdata[1], 32'hCAFEF00D);

    // Two wait-states, reset while a write is pending
    access(2, 32'h30, 4'b1111, 32'h0, s);
    check("n2_wr_stalls", 32'(s), 32'd3);
    access(2, 32'h34, 4'b1111, 32'h0BADCAFE, s);
    access(2, 32'h34, 4'b0000, 32'd0, s);
    check("n2_rd_data", rdata[2], 32'h0BADCAFE);
    idle(1);
    en[2] = 1'b1; addr[2] = 32'h30; wen[2] = 4'b1111; wdata[2] = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn[2] = 1'b0; en[2] = 1'b0; wen[2] = 4'b0000;
    #1;
    check("n2_rst_rdata", rdata[2], 32'd0);
    check("n2_rst_rvalid", 32'(rvalid[2]), 32'd0);
    check("n2_rst_stall", 32'(stall[2]), 32'd0);
    @(posedge clk); #1;
    rstn[2] = 1'b1;
    access(2, 32'h30, 4'b0000, 32'd0, s);
    check("n2_aborted_write", rdata[2], 32'h0);
    check("n2_post_rst_stalls", 32'(s), 32'd3);
    idle(1);

    // Upper address bits: wrap into word 0, or flagged when range checking is built in
    access(0, 32'h0, 4'b1111, 32'h55667788, s);
    access(0, 32'h00004000, 4'b1111, 32'h99999999, s);
    check("oor_wr_rvalid", 32'(rvalid[0]), 32'd1);
`ifdef DSRAM_RANGE_CHK_EN
    check("oor_wr_err", 32'(err[0]), 32'd1);
`endif
    access(0, 32'h0, 4'b0000, 32'd0, s);
    check("oor_word0", rdata[0], EXP_WORD0);
`ifdef DSRAM_RANGE_CHK_EN
    check("oor_rd_ok_err", 32'(err[0]), 32'd0);
    access(0, 32'h00004000, 4'b0000, 32'd0, s);
    check("oor_rd_err", 32'(err[0]), 32'd1);
    check("oor_rd_zero", rdata[0], 32'd0);
`endif
    idle(2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter: DEPTH_LOG2, default 12, sets the memory size in 32-bit words (2^DEPTH_LOG2 words).
REQ-002 Parameter: WAIT_CYCLES, default 0, range 0..7, sets the number of wait-states per access.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: data_sram_en  in  1  request valid.
REQ-006 Port: data_sram_wen  in  4  byte write enables; 4'b0000 means read.
REQ-007 Port: data_sram_addr  in  32  word-aligned byte address.
REQ-008 Port: data_sram_wdata  in  32  store data, already lane-replicated by the requester.
REQ-009 Port: data_sram_rdata  out  32  read data.
REQ-010 Port: data_sram_rvalid  out  1  one-cycle pulse: an access completed.
REQ-011 Port: data_sram_stallreq  out  1  requester must hold its request and stall.
REQ-012 Port: data_sram_err  out  1  out-of-range access flag; present only under DSRAM_RANGE_CHK_EN.

Function
REQ-013 States SHALL be IDLE, WAIT and RESP; the block SHALL accept new requests only in IDLE.
REQ-014 WAIT_CYCLES=0: an IDLE request SHALL be performed at the next edge, stallreq SHALL stay 0, rvalid SHALL be 1 in the following cycle, and back-to-back requests SHALL be accepted every cycle.
REQ-015 WAIT_CYCLES=N>0, stallreq: stallreq SHALL equal data_sram_en combinationally in IDLE.
REQ-016 WAIT_CYCLES=N>0, capture: at the accepting edge, addr, wen and wdata SHALL be latched, the counter SHALL be loaded with N-1, and the state SHALL go to WAIT.
REQ-017 In WAIT, stallreq SHALL be 1; at each edge, if the counter is 0 the latched access SHALL be performed and the state SHALL go to RESP, otherwise the counter SHALL decrement.
REQ-018 RESP SHALL last exactly one cycle, with rvalid=1 and stallreq=0, and SHALL ignore the still-asserted en (same request); the next state SHALL be IDLE.
REQ-019 Total stall for an N>0 access SHALL be N+1 cycles.
REQ-020 Write access: for each i with wen[i]=1, byte lane i of word addr[DEPTH_LOG2+1:2] SHALL take wdata[8i+7:8i]; other lanes SHALL be unchanged.
REQ-021 Read access (wen=0): rdata SHALL load the full word; rdata SHALL be unchanged by writes.
REQ-022 rdata SHALL hold its value until the next read access completes.
REQ-023 addr[1:0] SHALL be ignored.
REQ-024 A read of a word written by the immediately preceding access SHALL return the new data (no stale read).
REQ-025 en=0 in IDLE SHALL change no state and SHALL produce rvalid=0.

Reset
REQ-026 rst_n low SHALL force, asynchronously: state IDLE, counter 0, rdata 0, rvalid 0, err 0, latched request cleared.
REQ-027 Reset mid-WAIT SHALL abort the pending access with no memory write.
REQ-028 Memory array contents SHALL NOT be reset.

Configuration
REQ-029 With macro DSRAM_RANGE_CHK_EN defined: an access with any of addr[31:DEPTH_LOG2+2] nonzero SHALL suppress the write, return rdata=0 for reads, and pulse data_sram_err together with rvalid.
REQ-030 Without DSRAM_RANGE_CHK_EN: the data_sram_err port SHALL be absent, and upper address bits SHALL be ignored (wrap modulo depth).

Structure
REQ-031 Shared package dsram_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the WAIT_CYCLES maximum constant (7).
REQ-032 Sub-module dsram_bank SHALL implement the byte-writable 2^DEPTH_LOG2 x 32 synchronous array (write-enable per lane, registered read).

Verification
REQ-033 N=0: write addr 0x10, wen 4'b1111, wdata 0xDEADBEEF; then read 0x10 -> rdata 0xDEADBEEF with rvalid next cycle, stallreq always 0.
REQ-034 N=0: preset word 0x20 to 0x11223344; write wen 4'b0100, wdata 0xAAAAAAAA; read 0x20 -> 0x11AA3344.
REQ-035 N=3: read request held -> stallreq high exactly 4 cycles, rvalid 1 cycle in RESP, rdata held afterwards, single access only.
REQ-036 N=2: assert rst_n low during WAIT of a write to 0x30 (old value 0x0) -> state IDLE, outputs 0, read 0x30 returns 0x0.
REQ-037 DSRAM_RANGE_CHK_EN, DEPTH_LOG2=12: write 0x00004000 -> err and rvalid pulse together, word 0x0 unchanged; without the macro, the same write lands in word 0.
